if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 ID_allowin  input  1  decode stage can accept an instruction this cycle.
REQ-004 br_signal  input  33  {br_taken[32], br_target[31:0]} from decode, combinational, same cycle.
REQ-005 inst_sram_en  output  1  instruction SRAM read enable.
REQ-006 inst_sram_we  output  4  instruction SRAM byte write enables, constant 4'b0.
REQ-007 inst_sram_addr  output  32  fetch address (nextpc).
REQ-008 inst_sram_wdata  output  32  constant 32'b0.
REQ-009 inst_sram_rdata  input  32  read data; valid one cycle after an enabled read.
REQ-010 ID_signal_valid  output  1  ID_signal carries a live instruction.
REQ-011 ID_signal  output  64  {inst[63:32], pc[31:0]}.

Function
REQ-012 The block SHALL hold state: pc (32b), IF_valid (1b), and, when configured, buf_valid (1b) plus inst_buf (32b).
REQ-013 The pre-IF nextpc SHALL be br_target when br_taken = 1; otherwise it SHALL be pc + 4, modulo 2^32, wrapping 0xFFFFFFFC to 0x00000000.
REQ-014 IF_readygo SHALL be constant 1; IF_allowin SHALL be !IF_valid || ID_allowin.
REQ-015 inst_sram_en SHALL be IF_allowin && !reset; inst_sram_addr SHALL equal nextpc every cycle.
REQ-016 On a cycle with IF_allowin = 1 and reset = 0, the block SHALL load pc <= nextpc and IF_valid <= 1.
REQ-017 On a cycle with IF_allowin = 0, pc and IF_valid SHALL hold.
REQ-018 ID_signal_valid SHALL be IF_valid && !br_taken, which squashes the wrong-path instruction in IF in the same cycle a taken branch is in decode.
REQ-019 ID_signal[31:0] SHALL be pc; ID_signal[63:32] SHALL be the fetched instruction selected per REQ-026/027.
REQ-020 Fetch-to-ID latency SHALL be one cycle, with one instruction per cycle when ID_allowin stays high.
REQ-021 A redirect with br_taken = 1 and ID_allowin = 0 SHALL NOT change pc; the redirect takes effect on the first cycle ID_allowin = 1 while br_taken is still asserted.
REQ-022 A branch target is not checked for alignment; a misaligned target SHALL be issued unmodified.

Reset
REQ-023 While reset = 1, the block SHALL load pc <= 32'h1bfffffc, IF_valid <= 0, buf_valid <= 0 and inst_buf <= 0, and SHALL drive inst_sram_en = 0.
REQ-024 On the first cycle after reset is released, nextpc SHALL be 32'h1c000000 with inst_sram_en = 1, and ID_signal_valid SHALL be 0.
REQ-025 A reset asserted mid-stall or mid-redirect SHALL override all other updates in that cycle.

Configuration
REQ-026 With IF_INST_BUF_EN defined:
- When IF_valid = 1, ID_allowin = 0 and buf_valid = 0, the block SHALL capture inst_sram_rdata into inst_buf and set buf_valid.
- The instruction source SHALL be buf_valid ? inst_buf : inst_sram_rdata.
- buf_valid SHALL clear on any cycle with IF_allowin = 1.
REQ-027 With IF_INST_BUF_EN undefined, no buffer SHALL exist and the instruction SHALL be inst_sram_rdata directly; the SRAM is then relied on to hold its output while inst_sram_en = 0.

Verification
REQ-028 Release reset, ID_allowin = 1, br_taken = 0 -> inst_sram_addr = 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles; ID_signal pc lags addr by one cycle with valid = 1.
REQ-029 Steady fetch, then br_signal = {1, 0x1c000100} for one cycle -> ID_signal_valid = 0 that cycle; next pc = 0x1c000100; following addr = 0x1c000104.
REQ-030 ID_allowin = 0 for 3 cycles with IF_valid = 1 -> inst_sram_en = 0; pc and ID_signal are stable all 3 cycles; fetch resumes at pc + 4 when ID_allowin = 1.
REQ-031 With IF_INST_BUF_EN: SRAM model corrupts rdata during a 2-cycle stall -> ID_signal[63:32] keeps the original instruction; buf_valid clears on release.
REQ-032 Force pc = 0xFFFFFFFC, no branch -> next addr = 0x00000000. Separately, assert reset during a stall -> next cycle pc = 0x1bfffffc and ID_signal_valid = 0.

Source files
------------

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - bundle of fetch-stage handshake and instruction SRAM signals
//
// Purpose: groups the decode-side handshake (ID_allowin, br_signal,
//          ID_signal_valid, ID_signal) and the instruction SRAM port
//          (inst_sram_*) used by if_stage.
// Modports:
//    master - the fetch stage: drives inst_sram_en/we/addr/wdata,
//             ID_signal_valid and ID_signal; receives ID_allowin,
//             br_signal and inst_sram_rdata.
//    slave  - decode stage plus SRAM side: the mirror image.
interface if_stage_if;
   logic        ID_allowin;
   logic [32:0] br_signal;        // {br_taken, br_target}
   logic        inst_sram_en;
   logic [3:0]  inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;
   logic        ID_signal_valid;
   logic [63:0] ID_signal;        // {inst, pc}

   modport master (
      input  ID_allowin, br_signal, inst_sram_rdata,
      output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
             ID_signal_valid, ID_signal
   );

   modport slave (
      output ID_allowin, br_signal, inst_sram_rdata,
      input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
             ID_signal_valid, ID_signal
   );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with branch redirect and stall handling
//
// Purpose: computes nextpc (branch target or pc + 4), issues it to the
//          instruction SRAM, and hands {inst, pc} to decode one cycle later.
// Ports:
//    clk   - single clock, all state on rising edge
//    reset - synchronous, active-high
//    bus   - if_stage_if.master (decode handshake + instruction SRAM port)
// Configuration:
//    IF_INST_BUF_EN - when defined, adds a one-entry buffer that captures
//                     the SRAM read data on the first stalled cycle so the
//                     instruction survives the SRAM output changing.
//                     When undefined, the SRAM must hold its output while
//                     inst_sram_en is low.
module if_stage (
   input  logic       clk,
   input  logic       reset,
   if_stage_if.master bus
);

   localparam logic [31:0] RESET_PC = 32'h1bfffffc;

   logic [31:0] pc;
   logic        IF_valid;
   logic        br_taken;
   logic [31:0] br_target;
   logic [31:0] nextpc;
   logic        IF_readygo;
   logic        IF_allowin;
   logic [31:0] inst;

   assign br_taken  = bus.br_signal[32];
   assign br_target = bus.br_signal[31:0];

   // Target is issued unmodified, alignment is decode's concern.
   assign nextpc     = br_taken ? br_target : pc + 32'd4;
   assign IF_readygo = 1'b1;
   assign IF_allowin = !IF_valid || (IF_readygo && bus.ID_allowin);

   assign bus.inst_sram_en    = IF_allowin && !reset;
   assign bus.inst_sram_we    = 4'b0;
   assign bus.inst_sram_addr  = nextpc;
   assign bus.inst_sram_wdata = 32'b0;

   // A taken branch in decode means the instruction now in IF is wrong-path.
   assign bus.ID_signal_valid = IF_valid && !br_taken;
   assign bus.ID_signal       = {inst, pc};

   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= RESET_PC;
         IF_valid <= 1'b0;
      end else if (IF_allowin) begin
         pc       <= nextpc;
         IF_valid <= 1'b1;
      end
   end

`ifdef IF_INST_BUF_EN
   logic        buf_valid;
   logic [31:0] inst_buf;

   // Capture only on the first stalled cycle: rdata is still the response
   // to the last enabled read, later cycles may see it change.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_valid <= 1'b0;
         inst_buf  <= 32'b0;
      end else if (IF_allowin) begin
         buf_valid <= 1'b0;
      end else if (IF_valid && !bus.ID_allowin && !buf_valid) begin
         buf_valid <= 1'b1;
         inst_buf  <= bus.inst_sram_rdata;
      end
   end

   assign inst = buf_valid ? inst_buf : bus.inst_sram_rdata;
`else
   assign inst = bus.inst_sram_rdata;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

   logic clk = 1'b0;
   logic reset;
   logic corrupt;
   int   checks = 0;
   int   failures = 0;

   if_stage_if bus ();

   if_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hdead_beef;
   endfunction

   // SRAM model: one-cycle read latency, holds output while not enabled,
   // optionally scribbles on its output to exercise the fetch buffer.
   initial bus.inst_sram_rdata = 32'h0;
   always @(posedge clk) begin
      if (corrupt)
         bus.inst_sram_rdata <= 32'hbad0_bad0;
      else if (bus.inst_sram_en)
         bus.inst_sram_rdata <= inst_of(bus.inst_sram_addr);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_id(input string tag, input logic v, input logic [31:0] pc);
      check({tag, "_valid"}, bus.ID_signal_valid, v);
      check({tag, "_pc"}, bus.ID_signal[31:0], pc);
      if (v)
         check({tag, "_inst"}, bus.ID_signal[63:32], inst_of(pc));
   endtask

   initial begin
      logic [63:0] held;
      reset          = 1'b1;
      corrupt        = 1'b0;
      bus.ID_allowin = 1'b1;
      bus.br_signal  = 33'h0;
      tick;
      check("rst_en", bus.inst_sram_en, 1'b0);
      check("rst_we", bus.inst_sram_we, 4'b0);
      check("rst_wdata", bus.inst_sram_wdata, 32'b0);
      tick;
      check("rst_pc", bus.ID_signal[31:0], 32'h1bfffffc);
      check("rst_valid", bus.ID_signal_valid, 1'b0);

      // First cycle after release.
      reset = 1'b0;
      #1;
      check("post_rst_addr", bus.inst_sram_addr, 32'h1c000000);
      check("post_rst_en", bus.inst_sram_en, 1'b1);
      check("post_rst_valid", bus.ID_signal_valid, 1'b0);

      // Sequential fetch.
      tick;
      check("seq0_addr", bus.inst_sram_addr, 32'h1c000004);
      check_id("seq0", 1'b1, 32'h1c000000);
      tick;
      check("seq1_addr", bus.inst_sram_addr, 32'h1c000008);
      check_id("seq1", 1'b1, 32'h1c000004);

      // Taken branch squashes current IF instruction.
      bus.br_signal = {1'b1, 32'h1c000100};
      #1;
      check("br_squash", bus.ID_signal_valid, 1'b0);
      check("br_addr", bus.inst_sram_addr, 32'h1c000100);
      tick;
      bus.br_signal = 33'h0;
      #1;
      check_id("br_tgt", 1'b1, 32'h1c000100);
      check("br_next_addr", bus.inst_sram_addr, 32'h1c000104);

      // Three-cycle stall.
      bus.ID_allowin = 1'b0;
      #1;
      check("stall_en", bus.inst_sram_en, 1'b0);
      held = bus.ID_signal;
      for (int i = 0; i < 3; i++) begin
         tick;
         check($sformatf("stall%0d_en", i), bus.inst_sram_en, 1'b0);
         check($sformatf("stall%0d_id", i), bus.ID_signal, {inst_of(32'h1c000100), 32'h1c000100});
         check($sformatf("stall%0d_stable", i), bus.ID_signal, held);
      end
      bus.ID_allowin = 1'b1;
      #1;
      check("resume_addr", bus.inst_sram_addr, 32'h1c000104);
      check("resume_en", bus.inst_sram_en, 1'b1);
      tick;
      check_id("resume", 1'b1, 32'h1c000104);

      // Redirect while stalled waits for ID_allowin.
      bus.ID_allowin = 1'b0;
      bus.br_signal  = {1'b1, 32'h1c000200};
      tick;
      check("redir_hold_pc", bus.ID_signal[31:0], 32'h1c000104);
      check("redir_hold_valid", bus.ID_signal_valid, 1'b0);
      bus.ID_allowin = 1'b1;
      tick;
      bus.br_signal = 33'h0;
      #1;
      check_id("redir_take", 1'b1, 32'h1c000200);

      // Misaligned target passes through unmodified.
      bus.br_signal = {1'b1, 32'h1c000302};
      #1;
      check("misalign_addr", bus.inst_sram_addr, 32'h1c000302);
      tick;
      bus.br_signal = 33'h0;
      #1;
      check_id("misalign", 1'b1, 32'h1c000302);
      check("misalign_next", bus.inst_sram_addr, 32'h1c000306);

      // Wrap at top of address space.
      bus.br_signal = {1'b1, 32'hfffffffc};
      tick;
      bus.br_signal = 33'h0;
      #1;
      check_id("wrap_pc", 1'b1, 32'hfffffffc);
      check("wrap_addr", bus.inst_sram_addr, 32'h00000000);
      tick;
      check_id("wrap_zero", 1'b1, 32'h00000000);

`ifdef IF_INST_BUF_EN
      // SRAM output corrupted during a stall; buffered instruction survives.
      bus.ID_allowin = 1'b0;
      tick;
      corrupt = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick;
         check($sformatf("buf%0d_inst", i), bus.ID_signal[63:32], inst_of(32'h00000000));
      end
      corrupt = 1'b0;
      bus.ID_allowin = 1'b1;
      #1;
      check("buf_release_inst", bus.ID_signal[63:32], inst_of(32'h00000000));
      tick;
      check_id("buf_after", 1'b1, 32'h00000004);
      tick;
      check_id("buf_after2", 1'b1, 32'h00000008);
`endif

      // Reset asserted during a stall/redirect overrides everything.
      bus.ID_allowin = 1'b0;
      bus.br_signal  = {1'b1, 32'h1c000400};
      tick;
      reset = 1'b1;
      #1;
      check("rst_stall_en", bus.inst_sram_en, 1'b0);
      tick;
      reset = 1'b0;
      bus.br_signal = 33'h0;
      bus.ID_allowin = 1'b1;
      #1;
      check("rst_stall_pc", bus.ID_signal[31:0], 32'h1bfffffc);
      check("rst_stall_valid", bus.ID_signal_valid, 1'b0);
      check("rst_stall_addr", bus.inst_sram_addr, 32'h1c000000);
      tick;
      check_id("rst_stall_refetch", 1'b1, 32'h1c000000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
